// File: rtl/axis_slave_writer.sv
// AXI4-Stream slave: writes one armed frame (at most NUM_WORDS beats) into a word buffer.
// Latency: write port 1 cycle after each beat. Backpressure: tready is high only while receiving.
module axis_slave_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_WORDS   = 8,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   enable,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   wr_en,
    output logic [INDEX_WIDTH-1:0] wr_index,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic [INDEX_WIDTH-1:0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   err_tlast
);

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   enable_d_q, enable_d_d;
    logic                   tready_q, tready_d;
    logic                   wr_en_q, wr_en_d;
    logic [INDEX_WIDTH-1:0] wr_index_q, wr_index_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [INDEX_WIDTH-1:0] count_q, count_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic start;
    logic beat;
    logic at_last;

    assign start   = enable && !enable_d_q;
    assign beat    = s_axis_tvalid && tready_q;
    assign at_last = (count_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        enable_d_d = enable;
        tready_d   = tready_q;
        wr_en_d    = 1'b0;
        wr_index_d = wr_index_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RECV;
                    count_d  = '0;
                    err_d    = 1'b0;
                    tready_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            RECV: begin
                if (beat) begin
                    wr_en_d    = 1'b1;
                    wr_index_d = count_q;
                    wr_data_d  = s_axis_tdata;
                    count_d    = count_q + 1'b1;
                    if (s_axis_tlast || at_last) begin
                        // done is registered alongside the final write strobe
                        state_d  = DONE;
                        tready_d = 1'b0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        if (at_last && !s_axis_tlast) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                tready_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= IDLE;
            enable_d_q <= 1'b0;
            tready_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_index_q <= '0;
            wr_data_q  <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_d_q <= enable_d_d;
            tready_q   <= tready_d;
            wr_en_q    <= wr_en_d;
            wr_index_q <= wr_index_d;
            wr_data_q  <= wr_data_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign wr_en         = wr_en_q;
    assign wr_index      = wr_index_q;
    assign wr_data       = wr_data_q;
    assign count         = count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_tlast     = err_q;

endmodule

// File: tb/tb_axis_slave_writer.sv
// Directed bench for axis_slave_writer: full, gapped/short, missing-tlast, re-arm and mid-frame reset.
module tb_axis_slave_writer;

    logic        aclk;
    logic        areset;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [31:0] wr_data;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic        err_tlast;

    int total = 0;
    int bad   = 0;

    axis_slave_writer #(
        .DATA_WIDTH (32),
        .NUM_WORDS  (8),
        .INDEX_WIDTH(4)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .enable       (enable),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .wr_en        (wr_en),
        .wr_index     (wr_index),
        .wr_data      (wr_data),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .err_tlast    (err_tlast)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Drive one beat, clock it in, and check the write port the cycle after.
    task automatic beat(input int idx, input logic [31:0] data, input logic last,
                        input logic exp_done, input string tag);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = data;
        s_axis_tlast  = last;
        tick();
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        chk({tag, "_wr_index"}, 32'(wr_index), 32'(idx));
        chk({tag, "_wr_data"}, wr_data, data);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
    endtask

    task automatic arm(input string tag);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk({tag, "_tready"}, 32'(s_axis_tready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_err"}, 32'(err_tlast), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, 32'(s_axis_tready), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_index"}, 32'(wr_index), 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err_tlast), 32'd0);
    endtask

    initial begin
        areset        = 1'b1;
        enable        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        areset = 1'b0;
        tick();
        chk_all_zero("post_reset");

        // Full frame 0..7 with tlast on the eighth beat
        arm("full_arm");
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat(i, 32'(i), (i == 7), (i == 7), "full");
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("full_count", 32'(count), 32'd8);
        chk("full_err", 32'(err_tlast), 32'd0);
        chk("full_tready", 32'(s_axis_tready), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        tick();
        chk("full_done_clear", 32'(done), 32'd0);
        chk("full_wr_en_clear", 32'(wr_en), 32'd0);
        chk("full_count_hold", 32'(count), 32'd8);

        // Short frame with two idle cycles between beats
        arm("gap_arm");
        beat(0, 32'hA, 1'b0, 1'b0, "gap0");
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'hDEAD;
        s_axis_tlast  = 1'b1;
        tick();
        chk("gap_idle_wr_en", 32'(wr_en), 32'd0);
        chk("gap_idle_count", 32'(count), 32'd1);
        tick();
        chk("gap_idle2_wr_en", 32'(wr_en), 32'd0);
        beat(1, 32'hB, 1'b0, 1'b0, "gap1");
        s_axis_tvalid = 1'b0;
        tick();
        tick();
        chk("gap_idle3_count", 32'(count), 32'd2);
        beat(2, 32'hC, 1'b1, 1'b1, "gap2");
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("gap_count", 32'(count), 32'd3);
        chk("gap_err", 32'(err_tlast), 32'd0);
        chk("gap_tready", 32'(s_axis_tready), 32'd0);

        // Ten beats without tlast: only eight are accepted
        arm("notlast_arm");
        for (int i = 0; i < 8; i++) begin
            beat(i, 32'h50 + 32'(i), 1'b0, (i == 7), "notlast");
        end
        chk("notlast_err", 32'(err_tlast), 32'd1);
        chk("notlast_tready", 32'(s_axis_tready), 32'd0);
        for (int i = 8; i < 10; i++) begin
            s_axis_tdata = 32'h50 + 32'(i);
            tick();
            chk("notlast_extra_wr_en", 32'(wr_en), 32'd0);
            chk("notlast_extra_tready", 32'(s_axis_tready), 32'd0);
            chk("notlast_extra_count", 32'(count), 32'd8);
        end
        s_axis_tvalid = 1'b0;
        chk("notlast_err_sticky", 32'(err_tlast), 32'd1);

        // Enable held high after done must not start another frame
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_tready", 32'(s_axis_tready), 32'd0);
            chk("held_busy", 32'(busy), 32'd0);
            chk("held_err", 32'(err_tlast), 32'd1);
        end
        arm("rearm");
        for (int i = 0; i < 8; i++) begin
            beat(i, 32'h100 + 32'(i), (i == 7), (i == 7), "rearm");
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("rearm_count", 32'(count), 32'd8);
        chk("rearm_err", 32'(err_tlast), 32'd0);

        // Reset in the middle of a frame
        arm("mid_arm");
        for (int i = 0; i < 4; i++) begin
            beat(i, 32'h77 + 32'(i), 1'b0, 1'b0, "mid");
        end
        chk("mid_count", 32'(count), 32'd4);
        areset = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        s_axis_tvalid = 1'b0;
        enable        = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        arm("after_arm");
        for (int i = 0; i < 8; i++) begin
            beat(i, 32'h200 + 32'(i), (i == 7), (i == 7), "after");
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("after_count", 32'(count), 32'd8);
        chk("after_err", 32'(err_tlast), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
